// File: rtl/regfile_wb_sequencer_if.sv
// Write-port bus of the register file sequencer: two writeback requesters plus
// the registered register-file write controls.
interface regfile_wb_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;

  logic              RegWrite;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] Write_data;
  logic              init_done;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  RegWrite, Write_register, Write_data, init_done
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output RegWrite, Write_register, Write_data, init_done
  );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// Register file write-port controller: clears every register after reset, then
// arbitrates ALU and load writebacks round-robin onto the single write port.
module regfile_wb_sequencer #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_sequencer_if.slave bus
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              last_q, last_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              init_done_q, init_done_d;
  logic              alu_grant, mem_grant;

  // On contention the grant goes to whichever requester was not served last.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (state_q == StRun) begin
      if (bus.alu_valid && bus.mem_valid) begin
        alu_grant = last_q;
        mem_grant = ~last_q;
      end else begin
        alu_grant = bus.alu_valid;
        mem_grant = bus.mem_valid;
      end
    end
  end

  assign bus.alu_ready      = alu_grant;
  assign bus.mem_ready      = mem_grant;
  assign bus.RegWrite       = reg_write_q;
  assign bus.Write_register = wr_addr_q;
  assign bus.Write_data     = wr_data_q;
  assign bus.init_done      = init_done_q;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    last_d      = last_q;
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;

    unique case (state_q)
      StClear: begin
        reg_write_d = 1'b1;
        wr_addr_d   = clr_addr_q;
        wr_data_d   = '0;
        if (clr_addr_q == LastAddr) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      StRun: begin
        // r0 requests are consumed but never reach the register file.
        if (alu_grant) begin
          reg_write_d = |bus.alu_rd;
          wr_addr_d   = bus.alu_rd;
          wr_data_d   = bus.alu_data;
          last_d      = 1'b0;
        end else if (mem_grant) begin
          reg_write_d = |bus.mem_rd;
          wr_addr_d   = bus.mem_rd;
          wr_data_d   = bus.mem_data;
          last_d      = 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StClear;
      clr_addr_q  <= '0;
      last_q      <= 1'b0;
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      last_q      <= last_d;
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Scoreboard bench: the driver models the sequencer from its rules and queues
// expected register-file writes; a negedge monitor pops them as writes appear.
module tb_regfile_wb_sequencer;

  localparam int unsigned NumRegs = 32;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  regfile_wb_sequencer_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_wb_sequencer #(
    .NUM_REGS(NumRegs),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic exp_init = 1'b0;

  req_t alu_q[$];
  req_t mem_q[$];
  wr_t  exp_q[$];

  // Reference model state
  bit m_run  = 1'b0;
  int m_clr  = 0;
  int m_last = 0;  // 0 = ALU served last, 1 = MEM served last

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every write the DUT presents against the scoreboard.
  wr_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      check("init_done", 64'(bus.init_done), 64'(exp_init));
      if (bus.RegWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got r%0d=%0h, expected no write (cycle %0d)",
                   bus.Write_register, bus.Write_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 64'(bus.Write_register), 64'(e.rd));
          check("write_data", 64'(bus.Write_data), 64'(e.data));
          check("write_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (bus.RegWrite !== 1'b0) begin
        check("RegWrite_known", 64'(bus.RegWrite), 64'(0));
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("RegWrite_missing", 64'(bus.RegWrite), 64'(1));
      end
    end
  end

  // One clock of stimulus plus the reference model's view of that clock.
  task automatic cycle(input bit rst);
    bit   av, mv, ea, em;
    logic nxt_init;
    req_t r;
    reset = rst;
    av = alu_q.size() != 0;
    mv = mem_q.size() != 0;
    bus.alu_valid = av;
    bus.alu_rd    = av ? alu_q[0].rd : 5'($urandom);
    bus.alu_data  = av ? alu_q[0].data : $urandom;
    bus.mem_valid = mv;
    bus.mem_rd    = mv ? mem_q[0].rd : 5'($urandom);
    bus.mem_data  = mv ? mem_q[0].data : $urandom;
    #1;
    ea = 1'b0;
    em = 1'b0;
    if (m_run) begin
      if (av && mv) begin
        em = (m_last == 0);
        ea = (m_last == 1);
      end else begin
        ea = av;
        em = mv;
      end
    end
    check("alu_ready", 64'(bus.alu_ready), 64'(ea));
    check("mem_ready", 64'(bus.mem_ready), 64'(em));
    nxt_init = exp_init;
    if (rst) begin
      m_run    = 1'b0;
      m_clr    = 0;
      m_last   = 0;
      nxt_init = 1'b0;
    end else if (!m_run) begin
      exp_q.push_back('{rd: 5'(m_clr), data: 32'd0, cyc: cyc + 1});
      if (m_clr == NumRegs - 1) begin
        m_run    = 1'b1;
        nxt_init = 1'b1;
      end else begin
        m_clr++;
      end
    end else if (ea || em) begin
      r = ea ? alu_q.pop_front() : mem_q.pop_front();
      if (r.rd != 0) exp_q.push_back('{rd: r.rd, data: r.data, cyc: cyc + 1});
      m_last = ea ? 0 : 1;
    end
    @(posedge clk);
    exp_init = nxt_init;
    #1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((alu_q.size() != 0 || mem_q.size() != 0) && n < limit) begin
      cycle(1'b0);
      n++;
    end
    if (alu_q.size() != 0 || mem_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d requests pending, expected 0",
               alu_q.size() + mem_q.size());
      alu_q.delete();
      mem_q.delete();
    end
    repeat (3) cycle(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cycle(1'b1);

    // Full clear then idle
    repeat (40) cycle(1'b0);

    // Request held through the clear; accepted at the first RUN edge
    cycle(1'b1);
    alu_q.push_back('{rd: 5'd25, data: 32'd15});
    drain(40);

    // Contention: MEM first, then alternating
    alu_q.push_back('{rd: 5'd3, data: 32'h3});
    alu_q.push_back('{rd: 5'd3, data: 32'h3});
    mem_q.push_back('{rd: 5'd20, data: 32'hAB});
    mem_q.push_back('{rd: 5'd20, data: 32'hAB});
    drain(10);

    // r0 write is consumed but not performed
    alu_q.push_back('{rd: 5'd0, data: 32'hFFFF_FFFF});
    drain(5);

    // Back-to-back single requester
    for (int i = 1; i <= 4; i++) mem_q.push_back('{rd: 5'(i), data: $urandom});
    drain(10);

    // Reset while address 10 is being cleared
    cycle(1'b1);
    repeat (11) cycle(1'b0);
    cycle(1'b1);
    repeat (36) cycle(1'b0);

    // Random traffic
    repeat (300) begin
      if (alu_q.size() < 3 && $urandom_range(0, 1) == 1)
        alu_q.push_back('{rd: 5'($urandom), data: $urandom});
      if (mem_q.size() < 3 && $urandom_range(0, 2) == 0)
        mem_q.push_back('{rd: 5'($urandom), data: $urandom});
      cycle(1'b0);
    end
    drain(50);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
